multi_word_loader: RTL and testbench

MULTI_WORD_LOADER -- requirements
Module: multi_word_loader

---
 rtl/multi_word_loader_pkg.sv | 16 +
 rtl/multi_word_loader_nibble_mux.sv | 15 +
 rtl/multi_word_loader.sv | 130 +++++++++++++
 tb/tb_multi_word_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_word_loader_pkg.sv
// rtl/multi_word_loader_pkg.sv - shared state encoding and out_byte field layout
package multi_word_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int OB_MODE_MSB = 7;
    localparam int OB_MODE_LSB = 5;
    localparam int OB_RDY      = 4;
    localparam int OB_NIB_MSB  = 3;
    localparam int OB_NIB_LSB  = 0;

endpackage

// File: rtl/multi_word_loader_nibble_mux.sv
// rtl/multi_word_loader_nibble_mux.sv - combinational selection of nibble k of a W-bit word
module nibble_mux #(
    parameter int W  = 32,
    parameter int KW = $clog2(W / 4)
) (
    input  logic [W-1:0]  word,
    input  logic [KW-1:0] k,
    output logic [3:0]    nib
);

    always_comb begin
        nib = 4'(word >> {k, 2'b00});
    end

endmodule

// File: rtl/multi_word_loader.sv
// rtl/multi_word_loader.sv - latches a multi-word payload and streams it out one tagged nibble per enabled cycle
module multi_word_loader
    import multi_word_loader_pkg::*;
#(
    parameter int W      = 32,
    parameter int NWORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ena,
    input  logic                  abort,
    input  logic [2:0]            mode,
    input  logic                  lsb_first,
    input  logic [NWORDS*W-1:0]   words,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            out_byte
);

    localparam int NPW = W / 4;
    localparam int KW  = $clog2(NPW);
    localparam int WIW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0]  LAST_NIB  = KW'(NPW - 1);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(NWORDS - 1);

    state_e                state_q, state_d;
    logic [KW-1:0]         nib_cnt_q, nib_cnt_d;
    logic [WIW-1:0]        word_idx_q, word_idx_d;
    logic [NWORDS*W-1:0]   words_q, words_d;
    logic [2:0]            mode_q, mode_d;
    logic                  lsb_first_q, lsb_first_d;
    logic [7:0]            out_byte_q, out_byte_d;
    logic                  done_q, done_d;

    logic [W-1:0]          cur_word;
    logic [KW-1:0]         nib_sel;
    logic [3:0]            nib;

    // nib_cnt is the position within the word; nib_sel maps it to the physical nibble
    assign cur_word = W'(words_q >> (word_idx_q * W));
    assign nib_sel  = lsb_first_q ? nib_cnt_q : (LAST_NIB - nib_cnt_q);

    nibble_mux #(.W(W), .KW(KW)) u_nibble_mux (
        .word (cur_word),
        .k    (nib_sel),
        .nib  (nib)
    );

    always_comb begin
        state_d     = state_q;
        nib_cnt_d   = nib_cnt_q;
        word_idx_d  = word_idx_q;
        words_d     = words_q;
        mode_d      = mode_q;
        lsb_first_d = lsb_first_q;
        out_byte_d  = out_byte_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            out_byte_d = '0;
        end else if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        words_d     = words;
                        mode_d      = mode;
                        lsb_first_d = lsb_first;
                        nib_cnt_d   = '0;
                        word_idx_d  = '0;
                        state_d     = ST_SEND;
                    end
                end
                ST_SEND: begin
                    out_byte_d                         = '0;
                    out_byte_d[OB_MODE_MSB:OB_MODE_LSB] = mode_q;
                    out_byte_d[OB_RDY]                  = 1'b1;
                    out_byte_d[OB_NIB_MSB:OB_NIB_LSB]   = nib;
                    if (nib_cnt_q == LAST_NIB) begin
                        nib_cnt_d = '0;
                        if (word_idx_q == LAST_WORD) begin
                            state_d = ST_DONE;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    out_byte_d = '0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    out_byte_d = '0;
                    state_d    = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            nib_cnt_q   <= '0;
            word_idx_q  <= '0;
            words_q     <= '0;
            mode_q      <= '0;
            lsb_first_q <= 1'b0;
            out_byte_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            word_idx_q  <= word_idx_d;
            words_q     <= words_d;
            mode_q      <= mode_d;
            lsb_first_q <= lsb_first_d;
            out_byte_q  <= out_byte_d;
            done_q      <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign out_byte = out_byte_q;

endmodule

// File: tb/tb_multi_word_loader.sv
// tb/tb_multi_word_loader.sv - randomized and directed self-checking bench for multi_word_loader
module tb_multi_word_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ena = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        lsb_first = 1'b0;
    logic [63:0] words = 64'd0;
    logic [7:0]  words8 = 8'd0;

    logic        busy0, done0, busy1, done1;
    logic [7:0]  out0, out1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    multi_word_loader #(.W(32), .NWORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ena(ena), .abort(abort),
        .mode(mode), .lsb_first(lsb_first), .words(words),
        .busy(busy0), .done(done0), .out_byte(out0)
    );

    multi_word_loader #(.W(8), .NWORDS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .ena(ena), .abort(abort),
        .mode(mode), .lsb_first(lsb_first), .words(words8),
        .busy(busy1), .done(done1), .out_byte(out1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a transfer is the ordered list of tagged nibbles, followed by one done cycle.
    logic [7:0] seq [2][64];
    int         len [2] = '{0, 0};
    int         pos [2] = '{0, 0};
    bit         act [2] = '{0, 0};
    logic [7:0] eout [2] = '{8'd0, 8'd0};
    bit         edone [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                act[m] = 0; eout[m] = 8'd0; edone[m] = 0;
            end else if (abort) begin
                act[m] = 0; eout[m] = 8'd0; edone[m] = 0;
            end else if (ena) begin
                edone[m] = 0;
                if (!act[m]) begin
                    if (start) begin
                        int wbits, nw, npw, sh;
                        logic [63:0] wd;
                        wbits = (m == 0) ? 32 : 8;
                        nw    = (m == 0) ? 2 : 1;
                        wd    = (m == 0) ? words : {56'd0, words8};
                        npw   = wbits / 4;
                        len[m] = 0;
                        for (int i = 0; i < nw; i++)
                            for (int j = 0; j < npw; j++) begin
                                sh = lsb_first ? j : (npw - 1 - j);
                                seq[m][len[m]] = {mode, 1'b1, 4'((wd >> (i * wbits + 4 * sh)) & 64'hF)};
                                len[m]++;
                            end
                        pos[m] = 0;
                        act[m] = 1;
                    end
                end else if (pos[m] < len[m]) begin
                    eout[m] = seq[m][pos[m]];
                    pos[m]++;
                end else begin
                    eout[m] = 8'd0; edone[m] = 1; act[m] = 0;
                end
            end else begin
                edone[m] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy32", 32'(busy0), 32'(act[0]));
            check("model_done32", 32'(done0), 32'(edone[0]));
            check("model_out32",  32'(out0),  32'(eout[0]));
            check("model_busy8",  32'(busy1), 32'(act[1]));
            check("model_done8",  32'(done1), 32'(edone[1]));
            check("model_out8",   32'(out1),  32'(eout[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lit_msb [16] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8,
                                 8'hB9, 8'hBA, 8'hBB, 8'hBC, 8'hBD, 8'hBE, 8'hBF, 8'hB0};
    logic [7:0] lit_lsb [16] = '{8'hB8, 8'hB7, 8'hB6, 8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1,
                                 8'hB0, 8'hBF, 8'hBE, 8'hBD, 8'hBC, 8'hBB, 8'hBA, 8'hB9};
    localparam logic [63:0] PAYLOAD = 64'h9ABCDEF0_12345678;

    initial begin
        int busy_cnt;
        tick();
        tick();
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_out",  32'(out0),  32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        ena = 1'b1;

        // MSB-first transfer; W=8 instance runs 0xA5 alongside
        words = PAYLOAD; words8 = 8'hA5; mode = 3'd5; lsb_first = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy0 ? 1 : 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                words = {$urandom, $urandom}; words8 = 8'($urandom);
                check("w8_nib0", 32'(out1), 32'hBA);
            end
            if (i == 1) check("w8_nib1", 32'(out1), 32'hB5);
            if (i == 2) begin
                check("w8_done_out", 32'(out1), 32'h00);
                check("w8_done", 32'(done1), 32'd1);
            end
            check("msb_seq", 32'(out0), 32'(lit_msb[i]));
            busy_cnt += busy0 ? 1 : 0;
        end
        tick();
        busy_cnt += busy0 ? 1 : 0;
        check("msb_done_out", 32'(out0), 32'h00);
        check("msb_done", 32'(done0), 32'd1);
        check("msb_busy_cycles", 32'(busy_cnt), 32'd17);
        tick();
        check("done_one_cycle", 32'(done0), 32'd0);

        // LSB-first transfer
        words = PAYLOAD; lsb_first = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        words = 64'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("lsb_seq", 32'(out0), 32'(lit_lsb[i]));
        end
        tick();
        check("lsb_done", 32'(done0), 32'd1);
        tick();

        // ena stall after the 4th nibble
        words = PAYLOAD; lsb_first = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("stall_pre", 32'(out0), 32'hB4);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'(out0), 32'hB4);
        end
        ena = 1'b1;
        for (int i = 4; i < 16; i++) begin
            tick();
            check("stall_resume", 32'(out0), 32'(lit_msb[i]));
        end
        tick();
        check("stall_done", 32'(done0), 32'd1);
        tick();

        // abort after the 5th nibble with start also high
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_pre", 32'(out0), 32'hB5);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_out", 32'(out0), 32'h00);
        check("abort_done", 32'(done0), 32'd0);
        tick();
        check("abort_stays_idle", 32'(busy0), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_restart", 32'(out0), 32'hB1);
        repeat (17) tick();

        // start held through a transfer: ignored while busy, accepted right after done
        start = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check("held_start_seq", 32'(out0), 32'(lit_msb[i]));
        end
        tick();
        check("held_start_done", 32'(done0), 32'd1);
        tick();
        check("b2b_busy", 32'(busy0), 32'd1);
        start = 1'b0;
        tick();
        check("b2b_first", 32'(out0), 32'hB1);
        repeat (17) tick();

        // asynchronous reset mid-SEND
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", 32'(out0), 32'h00);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();

        // randomized traffic with a changing payload
        for (int c = 0; c < 4000; c++) begin
            ena       = ($urandom_range(0, 7) != 0);
            abort     = ($urandom_range(0, 63) == 0);
            start     = ($urandom_range(0, 3) == 0);
            mode      = 3'($urandom);
            lsb_first = 1'($urandom);
            words     = {$urandom, $urandom};
            words8    = 8'($urandom);
            tick();
        end
        ena = 1'b1; abort = 1'b0; start = 1'b0;
        repeat (40) tick();
        check("final_idle", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
